// File: rtl/mul_red_pkg.sv
// mul_red_pkg: shared constants and shadow entry type for the mul_Red_0 issue scheduler
package mul_red_pkg;
  localparam logic [1:0] SEL_INTT = 2'b10;
  localparam logic MODE_K = 1'b0;
  localparam logic MODE_D = 1'b1;
  localparam int SH_TAG_W = 16;
  typedef struct packed {
    logic                valid;
    logic                mode;
    logic                id;
    logic [SH_TAG_W-1:0] tag;
  } shadow_t;
endpackage

// File: rtl/mul_red_shadow_pipe.sv
// mul_red_shadow_pipe: LAT-deep shadow_t delay line (i_in -> o_last after LAT clocks, o_any = any stage valid)
module mul_red_shadow_pipe
  import mul_red_pkg::*;
#(
  parameter int LAT = 3
) (
  input  logic    clk,
  input  logic    rst,
  input  shadow_t i_in,
  output shadow_t o_last,
  output logic    o_any
);
  shadow_t r_st [LAT];
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < LAT; i++) r_st[i] <= '0;
    else begin
      r_st[0] <= i_in;
      for (int i = 1; i < LAT; i++) r_st[i] <= r_st[i-1];
    end
  always_comb begin
    o_any = 1'b0;
    for (int i = 0; i < LAT; i++) o_any = o_any | r_st[i].valid;
    o_last = r_st[LAT-1];
  end
endmodule

// File: rtl/mul_red_sched.sv
// mul_red_sched: round-robin issue scheduler for mul_Red_0; req0/req1 valid-ready in, a_o/w_o/sel_a_o/mul_red_mode_o to unit, unit_result in, rsp_* and busy out
module mul_red_sched
  import mul_red_pkg::*;
#(
  parameter int LAT   = 3,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [23:0]      req0_a,
  input  logic [23:0]      req0_w,
  input  logic [1:0]       req0_sel_a,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [23:0]      req1_a,
  input  logic [23:0]      req1_w,
  input  logic [1:0]       req1_sel_a,
  input  logic [TAG_W-1:0] req1_tag,
  output logic [23:0]      a_o,
  output logic [23:0]      w_o,
  output logic [1:0]       sel_a_o,
  output logic             mul_red_mode_o,
  input  logic [23:0]      unit_result,
  output logic             rsp_valid,
  output logic [23:0]      rsp_data,
  output logic             rsp_id,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy
);
  logic r_ptr, r_pend_v, r_pend_id, r_mode_hold;
  logic [23:0] r_a_pend;
  logic [TAG_W-1:0] r_pend_tag;
  shadow_t r_iss, w_last;
  logic w_elig0, w_elig1, w_gnt0, w_gnt1, w_gnt, w_intt, w_iss, w_iss_id, w_any;
  logic [23:0] w_a, w_w;
  logic [1:0] w_sel;
  logic [TAG_W-1:0] w_tag, w_iss_tag;
  // a pending INTT A owns the next a_o slot, so only INTT requests may be granted behind it
  always_comb begin
    w_elig0 = req0_valid && !(r_pend_v && req0_sel_a != SEL_INTT);
    w_elig1 = req1_valid && !(r_pend_v && req1_sel_a != SEL_INTT);
    w_gnt1 = w_elig1 && (r_ptr || !w_elig0);
    w_gnt0 = w_elig0 && !w_gnt1;
    w_gnt = w_gnt0 || w_gnt1;
    w_a = w_gnt1 ? req1_a : req0_a;
    w_w = w_gnt1 ? req1_w : req0_w;
    w_sel = w_gnt1 ? req1_sel_a : req0_sel_a;
    w_tag = w_gnt1 ? req1_tag : req0_tag;
    w_intt = w_gnt && w_sel == SEL_INTT;
    w_iss = r_pend_v || (w_gnt && !w_intt);
    w_iss_id = r_pend_v ? r_pend_id : w_gnt1;
    w_iss_tag = r_pend_v ? r_pend_tag : w_tag;
    req0_ready = w_gnt0 && !rst;
    req1_ready = w_gnt1 && !rst;
    mul_red_mode_o = w_last.valid ? w_last.mode : r_mode_hold;
    busy = r_pend_v || r_iss.valid || w_any || rsp_valid;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_ptr <= 1'b0;
      r_pend_v <= 1'b0;
      r_pend_id <= 1'b0;
      r_a_pend <= '0;
      r_pend_tag <= '0;
      r_iss <= '0;
      r_mode_hold <= MODE_K;
      a_o <= '0;
      w_o <= '0;
      sel_a_o <= 2'b00;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      rsp_id <= 1'b0;
      rsp_tag <= '0;
    end else begin
      r_ptr <= w_gnt ? w_gnt0 : r_ptr;
      r_pend_v <= w_intt;
      r_pend_id <= w_intt ? w_gnt1 : r_pend_id;
      r_a_pend <= w_intt ? w_a : r_a_pend;
      r_pend_tag <= w_intt ? w_tag : r_pend_tag;
      w_o <= w_gnt ? w_w : w_o;
      a_o <= w_iss ? (r_pend_v ? r_a_pend : w_a) : a_o;
      sel_a_o <= w_iss ? (r_pend_v ? SEL_INTT : w_sel) : 2'b00;
      r_iss <= w_iss ? '{1'b1, w_iss_id ? MODE_D : MODE_K, w_iss_id, SH_TAG_W'(w_iss_tag)} : '0;
      r_mode_hold <= mul_red_mode_o;
      rsp_valid <= w_last.valid;
      rsp_data <= w_last.valid ? unit_result : rsp_data;
      rsp_id <= w_last.valid ? w_last.id : rsp_id;
      rsp_tag <= w_last.valid ? TAG_W'(w_last.tag) : rsp_tag;
    end
  mul_red_shadow_pipe #(.LAT(LAT)) u_shadow (
    .clk    (clk),
    .rst    (rst),
    .i_in   (r_iss),
    .o_last (w_last),
    .o_any  (w_any)
  );
endmodule

// File: tb/tb_mul_red_sched.sv
// tb_mul_red_sched: randomized scoreboard bench for mul_red_sched with a behavioural unit and arbiter model
module tb_mul_red_sched;
  localparam int LAT = 3;
  localparam int TW = 4;
  typedef struct {
    logic          id;
    logic [TW-1:0] tag;
    logic [23:0]   data;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic v[2];
  logic [1:0] sel[2];
  logic [23:0] a[2], w[2];
  logic [TW-1:0] tg[2];
  logic req0_ready, req1_ready, mul_red_mode_o, rsp_valid, rsp_id, busy;
  logic [23:0] a_o, w_o, rsp_data, unit_result;
  logic [1:0] sel_a_o;
  logic [TW-1:0] rsp_tag;
  int vec = 0;
  int miss = 0;
  exp_t q[$];
  int m_ptr = 0;
  bit m_il = 1'b0;
  bit lg[2] = '{1'b0, 1'b0};
  bit pin = 1'b0;
  logic [23:0] pin_a, pin_w;
  logic [23:0] ua[LAT+1] = '{default: 24'h0};
  logic [23:0] uw[LAT+1] = '{default: 24'h0};
  logic [23:0] wprev = 24'h0;

  always #5 clk = ~clk;

  mul_red_sched #(.LAT(LAT), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(v[0]), .req0_ready(req0_ready), .req0_a(a[0]), .req0_w(w[0]), .req0_sel_a(sel[0]), .req0_tag(tg[0]),
    .req1_valid(v[1]), .req1_ready(req1_ready), .req1_a(a[1]), .req1_w(w[1]), .req1_sel_a(sel[1]), .req1_tag(tg[1]),
    .a_o(a_o), .w_o(w_o), .sel_a_o(sel_a_o), .mul_red_mode_o(mul_red_mode_o),
    .unit_result(unit_result),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_tag(rsp_tag), .busy(busy)
  );

  // Unit model: K reduction = a + w, D reduction = a ^ w; INTT ops use the w presented one cycle earlier.
  always @(negedge clk) begin
    for (int i = LAT; i > 0; i--) begin
      ua[i] = ua[i-1];
      uw[i] = uw[i-1];
    end
    ua[0] = a_o;
    uw[0] = (sel_a_o == 2'b10) ? wprev : w_o;
    wprev = w_o;
  end
  assign unit_result = mul_red_mode_o ? (ua[LAT] ^ uw[LAT]) : (ua[LAT] + uw[LAT]);

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  exp_t e;
  always @(negedge clk)
    if (!rst && rsp_valid) begin
      if (q.size() == 0) begin
        vec++;
        miss++;
        $display("FAIL rsp_unexpected got id=%0d tag=%0h data=%0h expected no response at %0t", rsp_id, rsp_tag, rsp_data, $time);
      end else begin
        e = q.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_tag", 32'(rsp_tag), 32'(e.tag));
        chk("rsp_data", 32'(rsp_data), 32'(e.data));
      end
    end

  function automatic logic [1:0] nsel();
    logic [1:0] s;
    s = 2'($urandom_range(0, 2));
    return (s == 2'b10) ? 2'b11 : s;
  endfunction

  // One cycle: new payload on ports that are idle or were granted last cycle, then check grants against the model.
  task automatic step(input bit w0, input bit i0, input bit w1, input bit i1, output int g);
    bit want[2];
    bit it[2];
    bit el[2];
    want = '{w0, w1};
    it = '{i0, i1};
    @(posedge clk);
    #1;
    for (int p = 0; p < 2; p++)
      if (!(v[p] && !lg[p])) begin
        v[p] = want[p];
        sel[p] = it[p] ? 2'b10 : nsel();
        a[p] = 24'($urandom);
        w[p] = 24'($urandom);
        tg[p] = TW'($urandom);
        if (pin && p == 0) begin
          a[0] = pin_a;
          w[0] = pin_w;
          sel[0] = 2'b00;
        end
      end
    #1;
    for (int p = 0; p < 2; p++) el[p] = v[p] && !(m_il && sel[p] != 2'b10);
    g = el[m_ptr] ? m_ptr : (el[1-m_ptr] ? 1 - m_ptr : -1);
    chk("ready0", 32'(req0_ready), 32'(g == 0));
    chk("ready1", 32'(req1_ready), 32'(g == 1));
    m_il = 1'b0;
    lg = '{1'b0, 1'b0};
    if (g >= 0) begin
      lg[g] = 1'b1;
      m_il = (sel[g] == 2'b10);
      m_ptr = 1 - g;
      q.push_back('{g == 1, tg[g], (g == 1) ? (a[1] ^ w[1]) : 24'(a[0] + w[0])});
    end
  endtask

  task automatic drain();
    int g;
    int n = 0;
    while (q.size() != 0 && n < 40) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, g);
      n++;
    end
    if (q.size() != 0) begin
      vec++;
      miss++;
      $display("FAIL drain_timeout got %0d pending responses expected 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int g;
    logic [23:0] ra, ha, hw;
    v = '{1'b1, 1'b1};
    sel = '{2'b00, 2'b00};
    a = '{24'h1, 24'h2};
    w = '{24'h3, 24'h4};
    tg = '{4'h0, 4'h0};
    #1 rst = 1'b1;
    #1;
    chk("rst_ready0", 32'(req0_ready), 0);
    chk("rst_ready1", 32'(req1_ready), 0);
    chk("rst_a_o", 32'(a_o), 0);
    chk("rst_w_o", 32'(w_o), 0);
    chk("rst_sel", 32'(sel_a_o), 0);
    chk("rst_mode", 32'(mul_red_mode_o), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    v = '{1'b0, 1'b0};
    repeat (2) @(negedge clk);
    rst = 1'b0;
    // single K op
    pin = 1'b1;
    pin_a = 24'h00A005;
    pin_w = 24'h002003;
    step(1'b1, 1'b0, 1'b0, 1'b0, g);
    pin = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0, g);
    chk("k_a_o", 32'(a_o), 32'h00A005);
    chk("k_w_o", 32'(w_o), 32'h002003);
    chk("k_sel", 32'(sel_a_o), 0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, g);
    chk("k_mode", 32'(mul_red_mode_o), 0);
    chk("k_busy", 32'(busy), 1);
    step(1'b0, 1'b0, 1'b0, 1'b0, g);
    chk("k_rsp_valid", 32'(rsp_valid), 1);
    chk("k_rsp_data", 32'(rsp_data), 32'h00C008);
    drain();
    // round robin with both ports streaming normal ops
    repeat (8) step(1'b1, 1'b0, 1'b1, 1'b0, g);
    drain();
    // INTT stream on port 1
    step(1'b0, 1'b0, 1'b1, 1'b1, g);
    ra = a[1];
    step(1'b0, 1'b0, 1'b1, 1'b1, g);
    chk("intt_t1_sel", 32'(sel_a_o), 0);
    step(1'b0, 1'b0, 1'b1, 1'b1, g);
    chk("intt_t2_a_o", 32'(a_o), 32'(ra));
    chk("intt_t2_sel", 32'(sel_a_o), 32'h2);
    step(1'b0, 1'b0, 1'b1, 1'b1, g);
    drain();
    // hazard: normal request behind an INTT grant
    step(1'b0, 1'b0, 1'b1, 1'b1, g);
    step(1'b1, 1'b0, 1'b0, 1'b0, g);
    chk("hz_blocked", 32'(req0_ready), 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, g);
    chk("hz_released", 32'(req0_ready), 1);
    chk("hz_intt_issue", 32'(sel_a_o), 32'h2);
    drain();
    // randomized traffic
    repeat (400) step($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 4, g);
    drain();
    // reset mid-flight
    step(1'b1, 1'b0, 1'b0, 1'b0, g);
    step(1'b0, 1'b0, 1'b1, 1'b0, g);
    step(1'b1, 1'b0, 1'b0, 1'b0, g);
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, g);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_a_o", 32'(a_o), 0);
    chk("mrst_w_o", 32'(w_o), 0);
    chk("mrst_sel", 32'(sel_a_o), 0);
    chk("mrst_rsp_valid", 32'(rsp_valid), 0);
    chk("mrst_rsp_tag", 32'(rsp_tag), 0);
    q.delete();
    m_ptr = 0;
    m_il = 1'b0;
    lg = '{1'b0, 1'b0};
    v = '{1'b0, 1'b0};
    @(negedge clk) rst = 1'b0;
    repeat (8) step(1'b0, 1'b0, 1'b0, 1'b0, g);
    chk("mrst_busy_after", 32'(busy), 0);
    step(1'b1, 1'b0, 1'b1, 1'b0, g);
    drain();
    // idle
    ha = a_o;
    hw = w_o;
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, g);
    chk("idle_sel", 32'(sel_a_o), 0);
    chk("idle_rsp_valid", 32'(rsp_valid), 0);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_a_o", 32'(a_o), 32'(ha));
    chk("idle_w_o", 32'(w_o), 32'(hw));
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
